sensor_alarm_ctrl: RTL and testbench

Sequencing controller wrapped around the four-sensor error detector. It registers the raw sensor vector and evaluates the error function. It debounces the result over a programmable number of consecutive cycles, then raises a latched alarm with a fault snapshot. The alarm is held until a supervisor acknowledges it, and re-arming is blocked until the fault condition clears.

---
 rtl/sensor_alarm_ctrl.sv | 131 +++++++++++++
 tb/tb_sensor_alarm_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_alarm_ctrl.sv
// Sensor alarm sequencing controller with debounce and latched alarm.
// Registers the raw 4-bit sensor vector and evaluates the error function on it.
// An alarm is raised after DEBOUNCE consecutive qualified error samples.
// The alarm is held until ack, and re-arming waits until the fault clears.
//
// Parameters:
//   DEBOUNCE   consecutive erroring samples needed to raise the alarm (1..255)
//   CNT_WIDTH  width of the saturating alarm-event counter
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   sensors     raw sensor vector (bit 0 = high-priority sensor)
//   enable      qualification enable; low blocks the start of a new alarm
//   ack         supervisor acknowledge, only honoured while the alarm is up
//   error_now   error function of the registered sample
//   alarm       registered alarm, high exactly while in ALARM
//   fault_code  sample captured on the edge entering ALARM
//   err_count   saturating count of alarm events
// Build option: SENSOR_ALARM_COUNT_EN keeps the event counter. Without it,
// err_count is tied to zero.

module sensor_alarm_ctrl #(
    parameter int DEBOUNCE  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           sensors,
    input  logic                 enable,
    input  logic                 ack,
    output logic                 error_now,
    output logic                 alarm,
    output logic [3:0]           fault_code,
    output logic [CNT_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        ALARM   = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    localparam logic [7:0] QUAL_LAST = 8'(DEBOUNCE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] qual_cnt;
    logic [7:0] qual_cnt_nxt;
    logic [3:0] sample_reg;
    logic       enter_alarm;

    assign error_now = sample_reg[0] | (sample_reg[1] & (sample_reg[2] | sample_reg[3]));

    always_comb begin
        state_nxt    = state;
        qual_cnt_nxt = qual_cnt;
        case (state)
            IDLE: begin
                if (error_now && enable) begin
                    if (DEBOUNCE == 1) begin
                        state_nxt = ALARM;
                    end else begin
                        state_nxt    = QUALIFY;
                        qual_cnt_nxt = 8'd1;
                    end
                end
            end
            QUALIFY: begin
                // Any gap in the qualified error restarts the streak from zero.
                if (!error_now || !enable) begin
                    state_nxt    = IDLE;
                    qual_cnt_nxt = 8'd0;
                end else if (qual_cnt == QUAL_LAST) begin
                    state_nxt = ALARM;
                end else begin
                    qual_cnt_nxt = qual_cnt + 8'd1;
                end
            end
            ALARM: begin
                // enable and error_now are deliberately ignored: alarm stays latched.
                if (ack) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                // A persistent fault must drop for a cycle before we can re-arm.
                if (!error_now) begin
                    state_nxt    = IDLE;
                    qual_cnt_nxt = 8'd0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                qual_cnt_nxt = 8'd0;
            end
        endcase
    end

    assign enter_alarm = (state != ALARM) && (state_nxt == ALARM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            qual_cnt   <= 8'd0;
            sample_reg <= 4'd0;
            alarm      <= 1'b0;
            fault_code <= 4'd0;
        end else begin
            state      <= state_nxt;
            qual_cnt   <= qual_cnt_nxt;
            sample_reg <= sensors;
            alarm      <= (state_nxt == ALARM);
            if (enter_alarm) begin
                fault_code <= sample_reg;
            end
        end
    end

`ifdef SENSOR_ALARM_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (enter_alarm && (err_count != {CNT_WIDTH{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// Testbench for sensor_alarm_ctrl: directed stimulus, streak-based reference
// model compared every cycle, plus literal expectations at key points.
module tb_sensor_alarm_ctrl;

`ifdef SENSOR_ALARM_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int DEB  = 4;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic       clk;
    logic       rst;
    logic [3:0] sensors;
    logic       enable;
    logic       ack;
    logic       error_now;
    logic       alarm;
    logic [3:0] fault_code;
    logic [CW-1:0] err_count;

    // Second instance: DEBOUNCE=1, 2-bit counter, for latency and saturation.
    logic [3:0] s_sensors;
    logic       s_enable;
    logic       s_ack;
    logic       s_error_now;
    logic       s_alarm;
    logic [3:0] s_fault_code;
    logic [1:0] s_err_count;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    sensor_alarm_ctrl #(.DEBOUNCE(DEB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .sensors(sensors), .enable(enable), .ack(ack),
        .error_now(error_now), .alarm(alarm), .fault_code(fault_code),
        .err_count(err_count)
    );

    sensor_alarm_ctrl #(.DEBOUNCE(1), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .sensors(s_sensors), .enable(s_enable), .ack(s_ack),
        .error_now(s_error_now), .alarm(s_alarm), .fault_code(s_fault_code),
        .err_count(s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit err_fn(input logic [3:0] s);
        return s[0] | (s[1] & (s[2] | s[3]));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the alarm rises when the run of consecutive qualified
    // error samples reaches DEB; after ack the model is blocked until one
    // non-error sample is seen.
    logic [3:0] m_sample;
    bit         m_alarm;
    bit         m_blocked;
    int         m_run;
    logic [3:0] m_fault;
    int         m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sample <= 4'd0; m_alarm <= 1'b0; m_blocked <= 1'b0;
            m_run <= 0; m_fault <= 4'd0; m_cnt <= 0;
        end else begin
            m_sample <= sensors;
            if (m_alarm) begin
                if (ack) begin
                    m_alarm   <= 1'b0;
                    m_blocked <= 1'b1;
                end
            end else if (m_blocked) begin
                if (!err_fn(m_sample)) m_blocked <= 1'b0;
            end else if (err_fn(m_sample) && enable) begin
                if (m_run + 1 >= DEB) begin
                    m_alarm <= 1'b1;
                    m_fault <= m_sample;
                    m_run   <= 0;
                    if (m_cnt < MAXC) m_cnt <= m_cnt + 1;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on && !rst) begin
            check("cyc_error_now", 32'(error_now), 32'(err_fn(m_sample)));
            check("cyc_alarm", 32'(alarm), 32'(m_alarm));
            check("cyc_fault_code", 32'(fault_code), 32'(m_fault));
            check("cyc_err_count", 32'(err_count), CNT_EN ? 32'(m_cnt) : 32'd0);
        end
    end

    task automatic hold(input logic [3:0] s, input logic en, input int n);
        @(negedge clk);
        sensors = s;
        enable  = en;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sensors = 4'd0; enable = 1'b1; ack = 1'b0;
        s_sensors = 4'd0; s_enable = 1'b1; s_ack = 1'b0;
        #3;
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_error_now", 32'(error_now), 32'd0);
        check("rst_fault", 32'(fault_code), 32'd0);
        check("rst_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cmp_on = 1'b1;
        repeat (2) @(negedge clk);

        // Debounce: 0110 stable before edge 0 -> alarm after edge 4.
        sensors = 4'b0110;
        repeat (4) @(posedge clk);
        #1 check("deb_alarm_edge3", 32'(alarm), 32'd0);
        @(posedge clk);
        #1;
        check("deb_alarm_edge4", 32'(alarm), 32'd1);
        check("deb_fault", 32'(fault_code), 32'b0110);
        check("deb_count", 32'(err_count), CNT_EN ? 32'd1 : 32'd0);

        // Ack with fault still present: alarm drops, no retrigger.
        @(negedge clk);
        sensors = 4'b0001;
        ack = 1'b1;
        @(posedge clk);
        #1 check("ack_release", 32'(alarm), 32'd0);
        @(negedge clk);
        ack = 1'b1;   // held ack outside ALARM must do nothing
        repeat (8) @(negedge clk);
        ack = 1'b0;
        check("persist_no_rearm", 32'(alarm), 32'd0);
        check("fault_kept", 32'(fault_code), 32'b0110);

        // Drop for one cycle, reapply -> second alarm after edge 4 of the reapply.
        sensors = 4'b0000;
        @(negedge clk);
        sensors = 4'b0001;
        repeat (4) @(posedge clk);
        #1 check("rearm_edge3", 32'(alarm), 32'd0);
        @(posedge clk);
        #1;
        check("rearm_alarm", 32'(alarm), 32'd1);
        check("rearm_fault", 32'(fault_code), 32'b0001);
        check("rearm_count", 32'(err_count), CNT_EN ? 32'd2 : 32'd0);
        @(negedge clk);
        sensors = 4'd0;
        ack_pulse();
        repeat (3) @(negedge clk);

        // Glitch: sensors drop for one cycle after edge 2 -> no alarm at edge 4.
        sensors = 4'b0110;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sensors = 4'b0000;
        @(negedge clk);
        sensors = 4'b0110;
        @(posedge clk);
        #1 check("glitch_no_alarm", 32'(alarm), 32'd0);
        repeat (8) @(negedge clk);
        check("glitch_late_alarm", 32'(alarm), 32'd1);
        sensors = 4'd0;
        ack_pulse();
        repeat (3) @(negedge clk);

        // Non-error patterns.
        hold(4'b1100, 1'b1, 20);
        check("noerr_1100", 32'({error_now, alarm}), 32'd0);
        hold(4'b0010, 1'b1, 20);
        check("noerr_0010", 32'({error_now, alarm}), 32'd0);
        hold(4'b1000, 1'b1, 20);
        check("noerr_1000", 32'({error_now, alarm}), 32'd0);

        // Enable gating.
        hold(4'b1010, 1'b0, 10);
        check("en_low_err", 32'(error_now), 32'd1);
        check("en_low_no_alarm", 32'(alarm), 32'd0);
        hold(4'b1010, 1'b1, 6);
        check("en_high_alarm", 32'(alarm), 32'd1);
        hold(4'b1010, 1'b0, 5);
        check("en_drop_in_alarm", 32'(alarm), 32'd1);
        sensors = 4'd0;
        enable = 1'b1;
        ack_pulse();
        check("en_ack_release", 32'(alarm), 32'd0);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-QUALIFY.
        sensors = 4'b0001;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_alarm", 32'(alarm), 32'd0);
        check("arst_err_now", 32'(error_now), 32'd0);
        check("arst_fault", 32'(fault_code), 32'd0);
        check("arst_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // Sensors were stable before the first post-reset edge: alarm after edge 4.
        repeat (4) @(posedge clk);
        #1 check("arst_idle_edge3", 32'(alarm), 32'd0);
        @(posedge clk);
        #1 check("arst_idle_edge4", 32'(alarm), 32'd1);
        @(negedge clk);
        sensors = 4'd0;
        ack_pulse();
        repeat (2) @(negedge clk);

        // DEBOUNCE=1 instance: latency one edge, counter saturates at 2'b11.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_sensors = 4'b0001;
            @(posedge clk);
            #1 check("sat_edge0", 32'(s_alarm), 32'd0);
            @(posedge clk);
            #1 check("sat_alarm_edge1", 32'(s_alarm), 32'd1);
            @(negedge clk);
            s_sensors = 4'd0;
            s_ack = 1'b1;
            @(negedge clk);
            s_ack = 1'b0;
            check("sat_release", 32'(s_alarm), 32'd0);
            repeat (2) @(negedge clk);
        end
        check("sat_count", 32'(s_err_count), CNT_EN ? 32'd3 : 32'd0);

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
